// File: rtl/maxt_pkg.sv
// maxt_pkg -- shared types and constants for the max-of-t test sequencer.
//   state_t     : sequencer states (IDLE, CLEAR, ARM, RUN, DRAIN, READOUT, DONE)
//   ERR_*       : err_code encodings reported to the host
//   NBINS_DEF   : default number of histogram bins
//   BIN_W       : width of one histogram bin / total counter
//   IDX_W       : width of the readout word index
package maxt_pkg;

  localparam int NBINS_DEF = 32;
  localparam int BIN_W     = 64;
  localparam int IDX_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ARM     = 3'd2,
    ST_RUN     = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_READOUT = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BADLEN   = 2'd1;
  localparam logic [1:0] ERR_UNDERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxt_rd_serializer.sv
// maxt_rd_serializer -- streams NBINS histogram bins followed by the sample
// total over a valid/ready interface. Each word is captured into an output
// register, so rd_data/rd_idx stay put while the sink stalls.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   load           : begin a new readout at word 0
//   clear          : abandon the readout immediately (has priority over load)
//   hist, total    : engine bins (packed, bin 0 in the LSBs) and total
//   rd_ready       : sink ready
//   rd_valid       : word valid
//   rd_data        : registered word (bin or total)
//   rd_idx         : word index, NBINS for the total
//   rd_last        : high on the total word
//   last_ack       : combinational, the total word is being accepted this cycle
module maxt_rd_serializer
  import maxt_pkg::*;
#(
  parameter int NBINS = NBINS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   clear,
  input  logic [NBINS*BIN_W-1:0] hist,
  input  logic [BIN_W-1:0]       total,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [BIN_W-1:0]       rd_data,
  output logic [IDX_W-1:0]       rd_idx,
  output logic                   rd_last,
  output logic                   last_ack
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBINS);

  // Word table: bins 0..NBINS-1, then the total at index NBINS.
  logic [BIN_W-1:0] word_arr [NBINS+1];

  genvar gi;
  generate
    for (gi = 0; gi < NBINS; gi++) begin : g_bin
      assign word_arr[gi] = hist[gi*BIN_W +: BIN_W];
    end
  endgenerate
  assign word_arr[NBINS] = total;

  logic                 valid_reg, valid_next;
  logic                 last_reg, last_next;
  logic [IDX_W-1:0]     idx_reg, idx_next, idx_inc;
  logic [BIN_W-1:0]     data_reg, data_next;
  logic                 ack;

  assign ack      = valid_reg & rd_ready;
  assign last_ack = ack & (idx_reg == LAST_IDX);
  assign idx_inc  = idx_reg + IDX_W'(1);

  always_comb begin
    valid_next = valid_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    if (clear) begin
      valid_next = 1'b0;
      idx_next   = '0;
      data_next  = '0;
      last_next  = 1'b0;
    end else if (load) begin
      valid_next = 1'b1;
      idx_next   = '0;
      data_next  = word_arr[0];
      last_next  = 1'b0;
    end else if (ack) begin
      if (idx_reg == LAST_IDX) begin
        // Total accepted: stream finished, park the outputs at zero.
        valid_next = 1'b0;
        idx_next   = '0;
        data_next  = '0;
        last_next  = 1'b0;
      end else begin
        idx_next  = idx_inc;
        data_next = word_arr[idx_inc];
        last_next = (idx_inc == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      idx_reg   <= '0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
    end
  end

  assign rd_valid = valid_reg;
  assign rd_idx   = idx_reg;
  assign rd_data  = data_reg;
  assign rd_last  = last_reg;

endmodule

// File: rtl/maxt_test_ctrl.sv
// maxt_test_ctrl -- sequencer for the max-of-t histogram engine.
// Clears the histogram, runs the engine for num_beats source beats, lets the
// histogram settle for DRAIN_CYC cycles and streams the bins plus the total to
// the host over valid/ready.
// Optional feature: define MAXT_CTRL_TIMEOUT_EN to give ARM a TIMEOUT_CYC
// watchdog (err_code 3). Without it ARM waits for src_valid indefinitely.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, num_beats      : run request (IDLE only) and beat count (multiple of 4, >0)
//   abort                 : return to IDLE from any state, no error
//   src_valid, src_ready  : random-source beat handshake
//   eng_enable, eng_rst   : engine enable and histogram clear
//   eng_hist, eng_total   : engine bins and total
//   rd_valid/ready/data/idx/last : readout stream
//   busy, done            : not-IDLE flag, one-cycle completion pulse
//   err, err_code         : sticky error and its cause
module maxt_test_ctrl
  import maxt_pkg::*;
#(
  parameter int BEATS_W     = 32,
  parameter int NBINS       = NBINS_DEF,
  parameter int DRAIN_CYC   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [BEATS_W-1:0]     num_beats,
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic                   eng_enable,
  output logic                   eng_rst,
  input  logic [NBINS*BIN_W-1:0] eng_hist,
  input  logic [BIN_W-1:0]       eng_total,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [BIN_W-1:0]       rd_data,
  output logic [IDX_W-1:0]       rd_idx,
  output logic                   rd_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code
);

  // One shared dwell counter times CLEAR, DRAIN and (optionally) ARM.
  localparam int CNT_MAX = max2(max2(DRAIN_CYC, TIMEOUT_CYC), 2);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [BEATS_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic                 busy_reg, busy_next;
  logic                 eng_rst_reg, eng_rst_next;
  logic                 run_reg, run_next;
  logic                 done_reg, done_next;
  logic                 err_reg, err_next;
  logic [1:0]           err_code_reg, err_code_next;

  logic accept, bad_len, underrun, timeout, arm_timeout;
  logic ser_load, ser_last_ack;

`ifdef MAXT_CTRL_TIMEOUT_EN
  assign arm_timeout = (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign arm_timeout = 1'b0;
`endif

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      beat_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      eng_rst_reg  <= 1'b0;
      run_reg      <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      beat_cnt_reg <= beat_cnt_next;
      busy_reg     <= busy_next;
      eng_rst_reg  <= eng_rst_next;
      run_reg      <= run_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
    end
  end

  // Next-state logic. abort outranks everything, including start in IDLE.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    bad_len    = 1'b0;
    underrun   = 1'b0;
    timeout    = 1'b0;
    ser_load   = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (num_beats == '0 || num_beats[1:0] != 2'b00) begin
              bad_len = 1'b1;
            end else begin
              accept     = 1'b1;
              state_next = ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          if (cnt_reg == CNT_W'(1)) state_next = ST_ARM;
        end
        ST_ARM: begin
          if (src_valid) begin
            state_next = ST_RUN;
          end else if (arm_timeout) begin
            timeout    = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_RUN: begin
          // A missing beat is checked before the completion test, so a gap
          // on the final beat still counts as an underrun.
          if (!src_valid) begin
            underrun   = 1'b1;
            state_next = ST_IDLE;
          end else if (beat_cnt_reg == BEATS_W'(1)) begin
            state_next = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cnt_reg == CNT_W'(DRAIN_CYC - 1)) begin
            state_next = ST_READOUT;
            ser_load   = 1'b1;
          end
        end
        ST_READOUT: begin
          if (ser_last_ack) state_next = ST_DONE;
        end
        ST_DONE:  state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values, decoded from the upcoming state so that
  // every output is a register that lines up with the state it belongs to.
  always_comb begin
    busy_next     = (state_next != ST_IDLE);
    eng_rst_next  = (state_next == ST_CLEAR);
    run_next      = (state_next == ST_RUN);
    done_next     = (state_next == ST_DONE);
    cnt_next      = (state_next == state_reg) ? cnt_reg + CNT_W'(1) : '0;

    beat_cnt_next = beat_cnt_reg;
    if (accept) begin
      beat_cnt_next = num_beats;
    end else if (state_reg == ST_RUN && beat_cnt_reg != '0) begin
      beat_cnt_next = beat_cnt_reg - BEATS_W'(1);
    end

    err_next      = err_reg;
    err_code_next = err_code_reg;
    if (accept) begin
      err_next      = 1'b0;
      err_code_next = ERR_NONE;
    end else if (bad_len) begin
      err_next      = 1'b1;
      err_code_next = ERR_BADLEN;
    end else if (underrun) begin
      err_next      = 1'b1;
      err_code_next = ERR_UNDERRUN;
    end else if (timeout) begin
      err_next      = 1'b1;
      err_code_next = ERR_TIMEOUT;
    end
  end

  maxt_rd_serializer #(
    .NBINS(NBINS)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ser_load),
    .clear    (abort),
    .hist     (eng_hist),
    .total    (eng_total),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_idx   (rd_idx),
    .rd_last  (rd_last),
    .last_ack (ser_last_ack)
  );

  assign busy       = busy_reg;
  assign eng_rst    = eng_rst_reg;
  assign eng_enable = run_reg;
  assign src_ready  = run_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign err_code   = err_code_reg;

endmodule

// File: tb/tb_maxt_test_ctrl.sv
// tb_maxt_test_ctrl -- self-checking bench for maxt_test_ctrl.
// The driver walks each run phase by phase (clear, arm, run, drain, readout,
// done) using the cycle counts the sequencer promises, publishing the
// expected outputs for every cycle; one compare process checks them at the
// falling edge. Output counters pin the phase lengths with literal values.
// Honours MAXT_CTRL_TIMEOUT_EN for the ARM watchdog scenario.
module tb_maxt_test_ctrl;

  localparam int NBINS       = 32;
  localparam int BEATS_W     = 32;
  localparam int DRAIN_CYC   = 8;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, start, abort, src_valid, rd_ready;
  logic [BEATS_W-1:0]     num_beats;
  logic [NBINS*64-1:0]    eng_hist;
  logic [63:0]            eng_total;
  logic                   src_ready, eng_enable, eng_rst, rd_valid, rd_last;
  logic                   busy, done, err;
  logic [63:0]            rd_data;
  logic [5:0]             rd_idx;
  logic [1:0]             err_code;

  maxt_test_ctrl #(
    .BEATS_W     (BEATS_W),
    .NBINS       (NBINS),
    .DRAIN_CYC   (DRAIN_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .num_beats  (num_beats),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .eng_enable (eng_enable),
    .eng_rst    (eng_rst),
    .eng_hist   (eng_hist),
    .eng_total  (eng_total),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_idx     (rd_idx),
    .rd_last    (rd_last),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference words: bins then total.
  logic [63:0] hist_m [NBINS+1];

  // Expected outputs for the current cycle.
  bit         chk_en = 1'b0;
  bit         e_busy, e_rst, e_run, e_valid, e_done, e_err;
  logic [1:0] e_code;
  int         e_idx;

  // Output activity counters.
  int m_busy, m_rst, m_rdy, m_en, m_valid, m_words, m_last, m_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",       64'(busy),       64'(e_busy));
      chk("eng_rst",    64'(eng_rst),    64'(e_rst));
      chk("eng_enable", 64'(eng_enable), 64'(e_run));
      chk("src_ready",  64'(src_ready),  64'(e_run));
      chk("rd_valid",   64'(rd_valid),   64'(e_valid));
      chk("done",       64'(done),       64'(e_done));
      chk("err",        64'(err),        64'(e_err));
      chk("err_code",   64'(err_code),   64'(e_code));
      if (e_valid) begin
        chk("rd_idx",  64'(rd_idx),  64'(e_idx));
        chk("rd_data", rd_data,      hist_m[e_idx]);
        chk("rd_last", 64'(rd_last), 64'(e_idx == NBINS));
      end
    end
  end

  always @(negedge clk) begin
    if (busy)       m_busy++;
    if (eng_rst)    m_rst++;
    if (src_ready)  m_rdy++;
    if (eng_enable) m_en++;
    if (rd_valid)   m_valid++;
    if (rd_valid && rd_ready) m_words++;
    if (rd_valid && rd_ready && rd_last) m_last++;
    if (done)       m_done++;
  end

  task automatic mon_clear();
    m_busy = 0; m_rst = 0; m_rdy = 0; m_en = 0;
    m_valid = 0; m_words = 0; m_last = 0; m_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_phase(input bit b, input bit r, input bit run,
                              input bit v, input int idx, input bit dn);
    e_busy = b; e_rst = r; e_run = run; e_valid = v; e_idx = idx; e_done = dn;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      expect_phase(0, 0, 0, 0, 0, 0);
      start = 1'b0;
      abort = 1'b0;
      tick();
    end
  endtask

  task automatic new_hist();
    for (int i = 0; i <= NBINS; i++) hist_m[i] = {$urandom, $urandom};
    for (int i = 0; i < NBINS; i++) eng_hist[i*64 +: 64] = hist_m[i];
    eng_total = hist_m[NBINS];
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},       64'(busy),       64'd0);
    chk({tag, "_eng_rst"},    64'(eng_rst),    64'd0);
    chk({tag, "_eng_enable"}, 64'(eng_enable), 64'd0);
    chk({tag, "_src_ready"},  64'(src_ready),  64'd0);
    chk({tag, "_rd_valid"},   64'(rd_valid),   64'd0);
    chk({tag, "_rd_data"},    rd_data,         64'd0);
    chk({tag, "_rd_idx"},     64'(rd_idx),     64'd0);
    chk({tag, "_rd_last"},    64'(rd_last),    64'd0);
    chk({tag, "_done"},       64'(done),       64'd0);
    chk({tag, "_err"},        64'(err),        64'd0);
    chk({tag, "_err_code"},   64'(err_code),   64'd0);
  endtask

  // Rejected start: nothing leaves IDLE, error BADLEN appears next cycle.
  task automatic do_bad(input int nb);
    expect_phase(0, 0, 0, 0, 0, 0);
    start = 1'b1;
    num_beats = BEATS_W'(nb);
    tick();
    start = 1'b0;
    e_err = 1'b1;
    e_code = 2'd1;
    idle_cycles(2);
  endtask

  // kind: 0 normal, 1 underrun at RUN beat 'at', 2 abort at RUN beat 'at',
  //       3 abort at readout cycle 'at', 4 reset at RUN beat 'at'.
  // rdy_mode: 0 random, 1 always ready, 2 pattern 1,0,0,1.
  task automatic do_run(input int nb, input int arm_dly, input int kind,
                        input int at, input int rdy_mode);
    int i;
    int k;
    expect_phase(0, 0, 0, 0, 0, 0);
    start = 1'b1;
    num_beats = BEATS_W'(nb);
    src_valid = 1'b0;
    abort = 1'b0;
    tick();
    start = 1'b0;
    num_beats = $urandom;
    e_err = 1'b0;
    e_code = 2'd0;
    // Histogram clear: two cycles.
    repeat (2) begin
      expect_phase(1, 1, 0, 0, 0, 0);
      src_valid = 1'($urandom_range(0, 1));
      tick();
    end
    // Waiting for the source.
    for (int a = 0; a <= arm_dly; a++) begin
      expect_phase(1, 0, 0, 0, 0, 0);
      src_valid = (a == arm_dly);
      tick();
    end
    // Exactly nb beats.
    for (int b = 1; b <= nb; b++) begin
      expect_phase(1, 0, 1, 0, 0, 0);
      src_valid = !(kind == 1 && b == at);
      abort = (kind == 2 && b == at);
      if (kind == 4 && b == at) begin
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("reset_in_run");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e_err = 1'b0;
        e_code = 2'd0;
        chk_en = 1'b1;
        idle_cycles(2);
        return;
      end
      tick();
      if ((kind == 1 || kind == 2) && b == at) begin
        abort = 1'b0;
        if (kind == 1) begin
          e_err = 1'b1;
          e_code = 2'd2;
        end
        idle_cycles(2);
        return;
      end
    end
    // Settling time.
    repeat (DRAIN_CYC) begin
      expect_phase(1, 0, 0, 0, 0, 0);
      src_valid = 1'($urandom_range(0, 1));
      tick();
    end
    // NBINS + 1 accepted words.
    i = 0;
    k = 0;
    while (i <= NBINS) begin
      expect_phase(1, 0, 0, 1, i, 0);
      case (rdy_mode)
        1:       rd_ready = 1'b1;
        2:       rd_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (k > 120) rd_ready = 1'b1;
      abort = (kind == 3 && k == at);
      tick();
      k++;
      if (abort) begin
        abort = 1'b0;
        idle_cycles(2);
        return;
      end
      if (rd_ready) i++;
    end
    expect_phase(1, 0, 0, 0, 0, 1);
    rd_ready = 1'($urandom_range(0, 1));
    tick();
    idle_cycles(1);
  endtask

  // Start a run and never supply a beat.
  task automatic arm_hold();
    expect_phase(0, 0, 0, 0, 0, 0);
    start = 1'b1;
    num_beats = BEATS_W'(8);
    src_valid = 1'b0;
    tick();
    start = 1'b0;
    e_err = 1'b0;
    e_code = 2'd0;
    repeat (2) begin
      expect_phase(1, 1, 0, 0, 0, 0);
      tick();
    end
`ifdef MAXT_CTRL_TIMEOUT_EN
    repeat (TIMEOUT_CYC) begin
      expect_phase(1, 0, 0, 0, 0, 0);
      tick();
    end
    e_err = 1'b1;
    e_code = 2'd3;
    idle_cycles(2);
    chk("timeout_busy_cycles", 64'(m_busy), 64'd18);
`else
    repeat (100) begin
      expect_phase(1, 0, 0, 0, 0, 0);
      tick();
    end
    expect_phase(1, 0, 0, 0, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    idle_cycles(2);
    chk("arm_hold_busy_cycles", 64'(m_busy), 64'd103);
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_beats = '0;
    src_valid = 1'b0; rd_ready = 1'b0; eng_hist = '0; eng_total = '0;
    e_err = 1'b0; e_code = 2'd0;
    expect_phase(0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= NBINS; i++) hist_m[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle_cycles(2);

    // Directed: 8 beats, source always valid, sink always ready.
    new_hist();
    mon_clear();
    do_run(8, 0, 0, 0, 1);
    chk("s1_eng_rst_cycles",   64'(m_rst),   64'd2);
    chk("s1_src_ready_cycles", 64'(m_rdy),   64'd8);
    chk("s1_enable_cycles",    64'(m_en),    64'd8);
    chk("s1_words",            64'(m_words), 64'd33);
    chk("s1_valid_cycles",     64'(m_valid), 64'd33);
    chk("s1_last_words",       64'(m_last),  64'd1);
    chk("s1_done_pulses",      64'(m_done),  64'd1);
    chk("s1_busy_cycles",      64'(m_busy),  64'd53);

    // Bad lengths.
    mon_clear();
    do_bad(6);
    do_bad(0);
    chk("badlen_busy_cycles",   64'(m_busy), 64'd0);
    chk("badlen_enable_cycles", 64'(m_en),   64'd0);

    // Underrun in the 5th beat of 16.
    new_hist();
    mon_clear();
    do_run(16, 1, 1, 5, 0);
    chk("underrun_enable_cycles", 64'(m_en),    64'd5);
    chk("underrun_valid_cycles",  64'(m_valid), 64'd0);

    // Stalling sink, ready pattern 1,0,0,1.
    new_hist();
    mon_clear();
    do_run(4, 2, 0, 0, 2);
    chk("stall_words",         64'(m_words), 64'd33);
    chk("stall_last_words",    64'(m_last),  64'd1);
    chk("stall_valid_cycles",  64'(m_valid), 64'd65);

    // Aborts in RUN and READOUT.
    new_hist();
    mon_clear();
    do_run(12, 0, 2, 3, 0);
    do_run(8, 1, 3, 10, 0);
    chk("abort_done_pulses", 64'(m_done), 64'd0);

    // Reset in RUN.
    new_hist();
    do_run(8, 0, 4, 3, 1);

    // Source never arrives.
    mon_clear();
    arm_hold();

    // Randomized runs.
    for (int r = 0; r < 24; r++) begin
      int sel;
      int nb;
      sel = $urandom_range(0, 9);
      new_hist();
      if (sel == 0) begin
        if ($urandom_range(0, 3) == 0) do_bad(0);
        else do_bad(4 * $urandom_range(0, 8) + $urandom_range(1, 3));
      end else begin
        nb = 4 * $urandom_range(1, 8);
        case (sel)
          6:       do_run(nb, $urandom_range(0, 4), 1, $urandom_range(1, nb), $urandom_range(0, 2));
          7:       do_run(nb, $urandom_range(0, 4), 2, $urandom_range(1, nb), $urandom_range(0, 2));
          8:       do_run(nb, $urandom_range(0, 4), 3, $urandom_range(0, 40), $urandom_range(0, 2));
          default: do_run(nb, $urandom_range(0, 4), 0, 0, $urandom_range(0, 2));
        endcase
      end
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/maxt_test_ctrl.md
# maxt_test_ctrl

Sequencer for the max-of-t histogram engine in the random-number analysis pipeline. It clears the engine's histogram, gates the engine enable and the random source for a programmed number of 4-word beats, then waits for the histogram to settle. It then streams the 32 bins plus the total count to the host readout path over a valid/ready interface. It sits between the host register block and the max-t engine and owns that engine exclusively.

## Interface
Parameters:
- BEATS_W, 32: width of the beat-count register.
- NBINS, 32: number of histogram bins read back.
- DRAIN_CYC, 8: idle cycles after RUN before readout.
- TIMEOUT_CYC, 1024: ARM watchdog limit. Used only with `MAXT_CTRL_TIMEOUT_EN`.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- start, in, 1: one-cycle request. Sampled only in IDLE.
- abort, in, 1: forces a return to IDLE from any state.
- num_beats, in, BEATS_W: beats to process. Latched on start.
- src_valid, in, 1: random source holds a valid 4×32 beat.
- src_ready, out, 1: source advances one beat per cycle while high.
- eng_enable, out, 1: max-t engine enable.
- eng_rst, out, 1: active-high histogram clear to the engine.
- eng_hist, in, NBINS×64: engine bin counters.
- eng_total, in, 64: engine sample total.
- rd_valid, out, 1: readout stream valid.
- rd_ready, in, 1: readout stream ready.
- rd_data, out, 64: bin value, or total on the last word.
- rd_idx, out, 6: 0..NBINS-1 for bins, NBINS for total.
- rd_last, out, 1: high on the total word.
- busy, out, 1: high whenever the state is not IDLE.
- done, out, 1: one-cycle pulse after the last word is accepted.
- err, out, 1: sticky error flag. Cleared on the next accepted start.
- err_code, out, 2: 0 none, 1 BADLEN, 2 UNDERRUN, 3 TIMEOUT.

## Operation
States and transitions:
- **IDLE**
  - start with num_beats==0 or num_beats[1:0]!=0: err=1, code BADLEN, stay in IDLE.
  - Otherwise: latch num_beats into beat_cnt, clear err, go to CLEAR.
- **CLEAR**: eng_rst=1 for 2 cycles, then go to ARM.
- **ARM**: wait for src_valid=1, then go to RUN.
- **RUN**
  - eng_enable=1 and src_ready=1 every cycle; beat_cnt decrements each cycle.
  - When beat_cnt reaches 1 and that beat completes, go to DRAIN.
  - src_valid=0 in any RUN cycle: err=1, code UNDERRUN, eng_enable drops, go to IDLE. The histogram is not read out.
- **DRAIN**: eng_enable=0 and src_ready=0. Count DRAIN_CYC cycles, then go to READOUT.
- **READOUT**
  - rd_valid=1; rd_idx starts at 0 and increments on each rd_valid&&rd_ready.
  - rd_data = eng_hist[rd_idx] for idx<NBINS, and eng_total at idx==NBINS with rd_last=1.
  - Handshake rule: while rd_valid&&!rd_ready, rd_data and rd_idx are held stable.
  - After the handshake at idx==NBINS, go to DONE.
- **DONE**: done=1 for one cycle, then go to IDLE.
- **abort**: in any non-IDLE state, go to IDLE next cycle. eng_enable, src_ready and rd_valid drop; no error is raised.
- **Simultaneous start and abort in IDLE**: abort wins; start is ignored.
- **Reset**: asynchronous to IDLE. All outputs are 0, beat_cnt=0, rd_idx=0. Reset in the middle of a run discards it.

## Timing
- All outputs are registered.
- start in cycle N gives busy=1 at N+1. eng_rst is high at N+1 and N+2. ARM is entered at N+3.
- First RUN cycle is ARM's cycle plus 1 when src_valid is already high.
- RUN lasts exactly num_beats cycles; src_ready is high for exactly that many cycles.
- DRAIN lasts DRAIN_CYC cycles; the engine pipeline plus histogram update needs at most 6.
- Readout takes NBINS+1 accepted handshakes; with rd_ready held high this is 33 cycles.
- rd_data is a registered copy. eng_hist is stable during READOUT because eng_enable=0.
- beat_cnt is BEATS_W bits with no wrap; 0 is rejected at start.

## Configuration
- `MAXT_CTRL_TIMEOUT_EN` defined:
  - ARM counts cycles.
  - Reaching TIMEOUT_CYC without src_valid sets err=1, code TIMEOUT, and returns to IDLE.
- Undefined: ARM waits indefinitely and code 3 is never produced.

## Structure
- Package maxt_pkg holds:
  - the state enum (IDLE, CLEAR, ARM, RUN, DRAIN, READOUT, DONE);
  - the err_code localparams;
  - the NBINS default and the bin width of 64.
- One sub-module, maxt_rd_serializer: the index counter, bin mux and output register for the valid/ready readout. The FSM drives its start/done.

## Test plan
- start, num_beats=8, src_valid held at 1, rd_ready=1:
  - eng_rst high 2 cycles, then src_ready high exactly 8 cycles;
  - then 8 drain cycles;
  - then 33 words with rd_idx 0..32 and rd_last only at 32;
  - done pulses once.
- num_beats=6, then num_beats=0: no busy; err=1, err_code=1 for each; eng_enable never high.
- num_beats=16, src_valid dropped in the 5th RUN cycle: err_code=2; eng_enable low on the next cycle; rd_valid never asserted.
- Readout with rd_ready toggling 1,0,0,1: rd_data and rd_idx are stable across stalls; the total is still the 33rd word.
- abort in RUN and again in READOUT: IDLE next cycle, err=0, done never pulses. rst_n low in RUN: all outputs 0 immediately.
- With `MAXT_CTRL_TIMEOUT_EN` and TIMEOUT_CYC=16, src_valid held at 0: err_code=3 after 16 ARM cycles. Without the macro, still in ARM after 100 cycles.
